display7_scan: RTL and testbench
================================

# display7_scan

Parametrised multiplexed driver for a row of common-anode 7-segment digits. It latches an N-digit hexadecimal value and scans the digits one at a time using a refresh prescaler. Each scan step drives one anode and that digit's segment pattern, with optional leading-zero blanking and per-digit decimal points. It sits between the datapath result registers and the board's display pins.

## Interface
Parameters:
- `N_DIGITS`, 4: number of digits scanned, ≥1.
- `CLK_HZ`, 27_000_000: input clock frequency.
- `REFRESH_HZ`, 1000: digit-step rate; `TICK_DIV = CLK_HZ/REFRESH_HZ`, must be ≥2.
- `SEG_ACTIVE_LOW`, 1: 1 = segments driven low-true.
- `AN_ACTIVE_LOW`, 1: 1 = anodes driven low-true.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `value_i`, in, 4*N_DIGITS: hex nibbles; nibble 0 (bits 3:0) is the rightmost digit.
- `load_i`, in, 1: when high at a rising edge, `value_i`, `dp_i` and `blank_lz_i` are captured into shadow registers.
- `dp_i`, in, N_DIGITS: decimal point request per digit.
- `blank_lz_i`, in, 1: enables leading-zero blanking.
- `seg_o`, out, 7: segments {g,f,e,d,c,b,a}, registered.
- `dp_o`, out, 1: decimal point, registered, same polarity as segments.
- `an_o`, out, N_DIGITS: anode selects, registered, one-hot when active.

## Operation
- Shadow registers: `val_q`, `dp_q`, `blz_q`. They are updated only on `load_i`. The display always shows shadow contents, never live inputs.
- Prescaler `tick_cnt` counts 0..TICK_DIV-1 and wraps. `tick` is asserted in the cycle where `tick_cnt == TICK_DIV-1`.
- Digit index `idx` advances on `tick`: 0→1→…→N_DIGITS-1→0. When N_DIGITS=1, `idx` stays at 0.
- Decode, with logical "on" = 1 before polarity inversion:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- Leading-zero blanking: digit k is blank when `blz_q`=1, k>0, and every nibble k..N_DIGITS-1 equals 0.
  - Digit 0 is never blanked, so the value 0 shows a single "0".
  - A blanked digit shows no segments and no decimal point, but its anode still strobes.
- Output polarity: logical outputs are inverted when the matching `*_ACTIVE_LOW` parameter is 1.
  - "All off" means every segment and anode inactive at the pin level.

## Timing
- Reset (asynchronous assert, synchronous-safe release): `tick_cnt`=0, `idx`=0, `val_q`=0, `dp_q`=0, `blz_q`=0.
  - `seg_o`, `dp_o` and `an_o` all inactive: all-ones with default parameters.
- First valid outputs appear in the first cycle after reset release: digit 0 showing "0", `an_o` one-hot at bit 0.
- Output registers load from `idx` and `val_q` every cycle. `an_o`, `seg_o` and `dp_o` change together, exactly one cycle after `idx` changes. No cycle ever pairs one digit's anode with another digit's segments.
- `load_i` updates shadows at that edge. The new value is visible on the outputs one cycle later, for whichever digit is currently selected. The scan position is not reset by `load_i`.
- `load_i` coincident with `tick`: both take effect. The next digit shows the new value.
- `load_i` held high: shadows track the inputs every cycle.
- Reset asserted mid-scan: outputs go inactive immediately (asynchronous) and the scan restarts at digit 0.
- Each digit is active for exactly TICK_DIV cycles. The full frame lasts N_DIGITS*TICK_DIV cycles.

## Structure
- Package `display_pkg`:
  - `seg7_t` typedef (logic [6:0]).
  - `SEG_BLANK` constant.
  - The 16-entry hex-to-segment lookup, as a constant array or function.
- Sub-module `display7_dec`: purely combinational nibble → `seg7_t`, logical polarity, instantiated once and fed by the nibble selected by `idx`.
- Top-level block holds the prescaler, index counter, shadow registers, blanking logic and output registers.

## Test plan
Bench parameters: N_DIGITS=4, CLK_HZ=100, REFRESH_HZ=25 (TICK_DIV=4), active-low.
- Reset: hold `rst_n`=0 → `seg_o`=7'h7F, `dp_o`=1, `an_o`=4'hF. After release, next cycle `an_o`=4'b1110 and `seg_o`=~7'b0111111. Each digit is held for 4 cycles.
- Load 16'h12CE, `dp_i`=4'b0100, `blank_lz_i`=0 → over one 16-cycle frame:
  - digit0 = E (~1111001)
  - digit1 = C (~0111001)
  - digit2 = 2 with `dp_o`=0
  - digit3 = 1
- Load 16'h00A0 with `blank_lz_i`=1 → digits 3 and 2 show `seg_o`=7'h7F (anodes still strobe), digit1 = A, digit0 = 0. Load 16'h0000 → only digit0 lit, showing "0".
- Pulse `load_i` in the same cycle as `tick` at `idx`=1 → the next digit (2) shows the new nibble. The scan sequence is unbroken.
- Assert `rst_n` low at `idx`=2 mid-dwell → all outputs inactive in the same cycle. Shadows cleared; after release the scan restarts at digit 0 showing "0".
- Sweep nibbles 0..F on digit 0 → `seg_o` matches the decode list for every code. Assert anode one-hot on every cycle after the first.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and the hex-to-segment lookup for the multiplexed 7-segment driver.
package display_pkg;

  // Segment pattern ordered {g,f,e,d,c,b,a}, logical polarity (1 = lit).
  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'b000_0000;

  // Hex nibble to logical segment pattern (lower-case b and d for 11 and 13).
  function automatic seg7_t hex_to_seg(input logic [3:0] nib);
    seg7_t seg;
    case (nib)
      4'h0:    seg = 7'b011_1111;
      4'h1:    seg = 7'b000_0110;
      4'h2:    seg = 7'b101_1011;
      4'h3:    seg = 7'b100_1111;
      4'h4:    seg = 7'b110_0110;
      4'h5:    seg = 7'b110_1101;
      4'h6:    seg = 7'b111_1101;
      4'h7:    seg = 7'b000_0111;
      4'h8:    seg = 7'b111_1111;
      4'h9:    seg = 7'b110_1111;
      4'hA:    seg = 7'b111_0111;
      4'hB:    seg = 7'b111_1100;
      4'hC:    seg = 7'b011_1001;
      4'hD:    seg = 7'b101_1110;
      4'hE:    seg = 7'b111_1001;
      4'hF:    seg = 7'b111_0001;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/display7_dec.sv
// Combinational nibble to 7-segment decoder, logical (active-high) polarity.
module display7_dec
  import display_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg7_t      seg_o
);

  // Pure lookup; polarity handling is left to the caller.
  always_comb begin
    seg_o = hex_to_seg(nib_i);
  end

endmodule

// File: rtl/display7_scan.sv
// Multiplexed common-anode 7-segment scanner: shadow-latched hex value,
// refresh prescaler, digit index, leading-zero blanking and registered pins.
module display7_scan
  import display_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int CLK_HZ         = 27_000_000,
  parameter int REFRESH_HZ     = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] value_i,
  input  logic                  load_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic                  blank_lz_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [N_DIGITS-1:0]   an_o
);

  localparam int TICK_DIV = CLK_HZ / REFRESH_HZ;
  localparam int CNT_W    = $clog2(TICK_DIV);
  localparam int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  // Pin-level "inactive" values, used at reset.
  localparam seg7_t                SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                 DP_OFF  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [N_DIGITS-1:0]  AN_OFF  = AN_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  logic [CNT_W-1:0]        tick_cnt_q, tick_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*N_DIGITS-1:0]   val_q, val_d;
  logic [N_DIGITS-1:0]     dp_q, dp_d;
  logic                    blz_q, blz_d;
  seg7_t                   seg_out_q, seg_out_d;
  logic                    dp_out_q, dp_out_d;
  logic [N_DIGITS-1:0]     an_out_q, an_out_d;

  logic                    tick_s;
  logic [3:0]              nib_s;
  logic                    dp_sel_s;
  logic                    hi_nonzero_s;
  logic                    blank_s;
  seg7_t                   dec_seg_s;
  seg7_t                   seg_log_s;
  logic                    dp_log_s;
  logic [N_DIGITS-1:0]     an_log_s;

  // Prescaler wrap and digit index advance.
  always_comb begin
    tick_s     = (tick_cnt_q == CNT_LAST);
    tick_cnt_d = tick_cnt_q;
    idx_d      = idx_q;
    if (tick_s) begin
      tick_cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      tick_cnt_d = tick_cnt_q + CNT_W'(1);
    end
  end

  // Shadow registers only follow the inputs while load_i is high.
  always_comb begin
    val_d = val_q;
    dp_d  = dp_q;
    blz_d = blz_q;
    if (load_i) begin
      val_d = value_i;
      dp_d  = dp_i;
      blz_d = blank_lz_i;
    end else begin
      val_d = val_q;
      dp_d  = dp_q;
      blz_d = blz_q;
    end
  end

  // Select the current digit's nibble and dp request, and build the one-hot anode.
  always_comb begin
    nib_s    = 4'h0;
    dp_sel_s = 1'b0;
    an_log_s = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib_s       = val_q[4*k +: 4];
        dp_sel_s    = dp_q[k];
        an_log_s[k] = 1'b1;
      end else begin
        an_log_s[k] = 1'b0;
      end
    end
  end

  // A digit is a leading zero when it and every digit to its left are zero.
  always_comb begin
    hi_nonzero_s = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if ((IDX_W'(k) >= idx_q) && (val_q[4*k +: 4] != 4'h0)) begin
        hi_nonzero_s = 1'b1;
      end else begin
        hi_nonzero_s = hi_nonzero_s;
      end
    end
    blank_s = blz_q && (idx_q != '0) && !hi_nonzero_s;
  end

  display7_dec u_dec (
    .nib_i (nib_s),
    .seg_o (dec_seg_s)
  );

  // Logical output values, then pin polarity.
  always_comb begin
    if (blank_s) begin
      seg_log_s = SEG_BLANK;
      dp_log_s  = 1'b0;
    end else begin
      seg_log_s = dec_seg_s;
      dp_log_s  = dp_sel_s;
    end
    if (SEG_ACTIVE_LOW) begin
      seg_out_d = ~seg_log_s;
      dp_out_d  = ~dp_log_s;
    end else begin
      seg_out_d = seg_log_s;
      dp_out_d  = dp_log_s;
    end
    if (AN_ACTIVE_LOW) begin
      an_out_d = ~an_log_s;
    end else begin
      an_out_d = an_log_s;
    end
  end

  // State, shadow and output registers; all outputs go inactive on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      idx_q      <= '0;
      val_q      <= '0;
      dp_q       <= '0;
      blz_q      <= 1'b0;
      seg_out_q  <= SEG_OFF;
      dp_out_q   <= DP_OFF;
      an_out_q   <= AN_OFF;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      idx_q      <= idx_d;
      val_q      <= val_d;
      dp_q       <= dp_d;
      blz_q      <= blz_d;
      seg_out_q  <= seg_out_d;
      dp_out_q   <= dp_out_d;
      an_out_q   <= an_out_d;
    end
  end

  assign seg_o = seg_out_q;
  assign dp_o  = dp_out_q;
  assign an_o  = an_out_q;

endmodule

// File: tb/tb_display7_scan.sv
// Scoreboard bench for display7_scan: N_DIGITS=4, TICK_DIV=4, active-low pins.
// Stimulus pushes cycle-tagged expectations; a negedge monitor consumes them.
module tb_display7_scan;

  logic        clk;
  logic        rst_n;
  logic [15:0] value_i;
  logic        load_i;
  logic [3:0]  dp_i;
  logic        blank_lz_i;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;

  typedef struct {
    int         cyc;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int gcyc     = 0;
  int rel0     = 1000000;
  int n_checks = 0;
  int n_fail   = 0;

  // Logical patterns for hex 0..F, {g,f,e,d,c,b,a}.
  logic [6:0] seg_tab [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };
  logic [3:0] an_pin [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  display7_scan #(
    .N_DIGITS       (4),
    .CLK_HZ         (100),
    .REFRESH_HZ     (25),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_i    (value_i),
    .load_i     (load_i),
    .dp_i       (dp_i),
    .blank_lz_i (blank_lz_i),
    .seg_o      (seg_o),
    .dp_o       (dp_o),
    .an_o       (an_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used to tag expectations.
  always @(posedge clk) gcyc <= gcyc + 1;

  task automatic wait_to(input int c);
    while (gcyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int c, input logic [6:0] seg, input logic dp,
                      input logic [3:0] an, input string nm);
    exp_t e;
    e.cyc = c;
    e.seg = seg;
    e.dp  = dp;
    e.an  = an;
    e.nm  = nm;
    exp_q.push_back(e);
  endtask

  // Digit d of the frame starting at cycle f is on the pins for 4 cycles.
  task automatic push_digit(input int f, input int d, input logic [6:0] seg,
                            input logic dp, input string nm);
    for (int i = 0; i < 4; i++) begin
      push(f + 4*d + i, seg, dp, an_pin[d], nm);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic blz);
    value_i    = v;
    dp_i       = dp;
    blank_lz_i = blz;
    load_i     = 1'b1;
    @(posedge clk);
    #1;
    load_i = 1'b0;
  endtask

  // Monitor: consume expectations due this cycle, and check anode one-hot.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= gcyc) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if (mon_e.cyc < gcyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d not checked (now cycle %0d)",
                 mon_e.nm, mon_e.cyc, gcyc);
      end else if (seg_o !== mon_e.seg || dp_o !== mon_e.dp || an_o !== mon_e.an) begin
        n_fail++;
        $display("FAIL %s cyc %0d: got seg=%h dp=%b an=%b, expected seg=%h dp=%b an=%b",
                 mon_e.nm, gcyc, seg_o, dp_o, an_o, mon_e.seg, mon_e.dp, mon_e.an);
      end
    end
    if (rst_n && gcyc > rel0) begin
      n_checks++;
      if ($countones(~an_o) != 1) begin
        n_fail++;
        $display("FAIL an_onehot cyc %0d: got an=%b, expected exactly one low bit", gcyc, an_o);
      end
    end
  end

  // Bound on total run time.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b1;
    value_i    = 16'h0000;
    load_i     = 1'b0;
    dp_i       = 4'b0000;
    blank_lz_i = 1'b0;
    #2 rst_n = 1'b0;

    // Reset hold: everything inactive.
    wait_to(2);
    push(2, 7'h7F, 1'b1, 4'hF, "reset_hold");
    wait_to(3);
    push(3, 7'h7F, 1'b1, 4'hF, "reset_hold");
    rst_n = 1'b1;
    rel0  = 3;
    // First frame starts at cycle 4: digit0 "0" for 4 cycles, then digit1.
    push_digit(4, 0, 7'h40, 1'b1, "first_digit0");
    push(8, 7'h40, 1'b1, 4'b1101, "digit1_after_dwell");

    // 12CE with dp on digit 2, no blanking; frame at 20.
    wait_to(8);
    do_load(16'h12CE, 4'b0100, 1'b0);
    push_digit(20, 0, 7'h06, 1'b1, "12CE_d0_E");
    push_digit(20, 1, 7'h46, 1'b1, "12CE_d1_C");
    push_digit(20, 2, 7'h24, 1'b0, "12CE_d2_2dp");
    push_digit(20, 3, 7'h79, 1'b1, "12CE_d3_1");

    // 00A0 with blanking; dp request on a blanked digit is suppressed; frame at 36.
    wait_to(34);
    do_load(16'h00A0, 4'b1000, 1'b1);
    push_digit(36, 0, 7'h40, 1'b1, "00A0_d0_0");
    push_digit(36, 1, 7'h08, 1'b1, "00A0_d1_A");
    push_digit(36, 2, 7'h7F, 1'b1, "00A0_d2_blank");
    push_digit(36, 3, 7'h7F, 1'b1, "00A0_d3_blank_dp");

    // 0000 with blanking: only digit0 lit; frame at 52.
    wait_to(50);
    do_load(16'h0000, 4'b0000, 1'b1);
    push_digit(52, 0, 7'h40, 1'b1, "zero_d0");
    push_digit(52, 1, 7'h7F, 1'b1, "zero_d1_blank");
    push_digit(52, 2, 7'h7F, 1'b1, "zero_d2_blank");
    push_digit(52, 3, 7'h7F, 1'b1, "zero_d3_blank");

    // Load coincident with the tick that leaves idx=1 (edge 75).
    wait_to(74);
    push(75, 7'h7F, 1'b1, 4'b1101, "tick_load_old_d1");
    do_load(16'h0500, 4'b0100, 1'b0);
    push_digit(68, 2, 7'h12, 1'b0, "tick_load_new_d2");
    push_digit(68, 3, 7'h40, 1'b1, "tick_load_d3");

    // Asynchronous reset while idx=2 mid-dwell.
    wait_to(93);
    rst_n = 1'b0;
    push(93, 7'h7F, 1'b1, 4'hF, "midscan_reset_async");
    push(94, 7'h7F, 1'b1, 4'hF, "midscan_reset_hold");
    push(95, 7'h7F, 1'b1, 4'hF, "midscan_reset_hold");
    wait_to(95);
    rst_n = 1'b1;
    rel0  = 95;
    push_digit(96, 0, 7'h40, 1'b1, "post_reset_d0");
    push_digit(96, 2, 7'h40, 1'b1, "post_reset_d2_cleared");

    // Sweep every nibble on digit 0, one per frame.
    for (int n = 0; n < 16; n++) begin
      logic [3:0] nib;
      int         f;
      nib = 4'(n);
      f   = 128 + 16*n;
      wait_to(f - 2);
      do_load({12'h000, nib}, 4'b0000, 1'b0);
      push_digit(f, 0, ~seg_tab[n], 1'b1, $sformatf("sweep_%h", nib));
    end

    wait_to(380);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
